pak_dsp_cfg_loader: RTL and testbench

Register-bus initiator that programs a pak_dsp instance. It accepts a stream of filter coefficients and issues one write per coefficient into the contiguous coefficient window. It then writes the control register and pulses done. It drives the addr/write_en/wdata/rdata port of pak_dsp, and sits between a host/config stream and the DSP core.

---
 rtl/pak_dsp_cfg_loader_if.sv | 30 +++
 rtl/pak_dsp_cfg_loader.sv | 161 ++++++++++++++++
 tb/tb_pak_dsp_cfg_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pak_dsp_cfg_loader_if.sv
// pak_dsp_cfg_loader_if: bundles the config-stream handshake and the
// pak_dsp register-bus signals of the coefficient loader.
//   master : the loader (drives coeff_ready, addr/write_en/wdata, status)
//   slave  : host + pak_dsp side (drives start, coeff stream, rdata)
interface pak_dsp_cfg_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [DATA_WIDTH-1:0] coeff_data;
  logic                  coeff_valid;
  logic                  coeff_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, coeff_data, coeff_valid, rdata,
    output coeff_ready, addr, write_en, wdata, busy, done, error
  );

  modport slave (
    output start, coeff_data, coeff_valid, rdata,
    input  coeff_ready, addr, write_en, wdata, busy, done, error
  );
endinterface

// File: rtl/pak_dsp_cfg_loader.sv
// pak_dsp_cfg_loader: register-bus initiator that programs a pak_dsp.
// Takes NUM_COEFF coefficients from a valid/ready stream, writes each to
// COEFF_BASE+idx, then writes CTRL_VALUE to CTRL_ADDR and pulses done.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pak_dsp_cfg_loader_if.master: start, coeff_data/valid/ready,
//          addr/write_en/wdata/rdata, busy, done, error
// Optional build macro PAK_DSP_CFG_VERIFY_EN: keeps a copy of every
// coefficient and reads the window back after the CTRL write; any
// readback mismatch sets a sticky error. Without it error is 0 and rdata
// is ignored.
module pak_dsp_cfg_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_COEFF  = 16,
  parameter int COEFF_BASE = 31,
  parameter int CTRL_ADDR  = 0,
  parameter int CTRL_VALUE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pak_dsp_cfg_loader_if.master  bus
);
  localparam int IW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(COEFF_BASE);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(CTRL_ADDR);
  localparam logic [DATA_WIDTH-1:0] CTRL_V = DATA_WIDTH'(CTRL_VALUE);
  localparam logic [IW-1:0]         LAST   = IW'(NUM_COEFF - 1);

  // The coefficient window must fit in the address space.
  if (COEFF_BASE + NUM_COEFF > (1 << ADDR_WIDTH)) begin : g_cfg_chk
    $error("pak_dsp_cfg_loader: COEFF_BASE+NUM_COEFF exceeds address space");
  end

`ifdef PAK_DSP_CFG_VERIFY_EN
  typedef enum logic [2:0] {IDLE, LOAD, CTRL, VERIFY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, CTRL, DONE} state_t;
`endif

  state_t                st, st_n;
  logic [IW-1:0]         idx, idx_n;
  logic                  ctrl_sent, ctrl_sent_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic                  we_q, we_n;
  logic                  err_q, err_n;
  logic                  accept;

  assign accept = bus.coeff_valid && (st == LOAD);

`ifdef PAK_DSP_CFG_VERIFY_EN
  logic [DATA_WIDTH-1:0] shadow [NUM_COEFF];

  // Copy of each accepted coefficient for the readback pass.
  always_ff @(posedge clk) begin
    if (accept) shadow[idx] <= bus.coeff_data;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      idx       <= '0;
      ctrl_sent <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st        <= st_n;
      idx       <= idx_n;
      ctrl_sent <= ctrl_sent_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      we_q      <= we_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    st_n        = st;
    idx_n       = idx;
    ctrl_sent_n = ctrl_sent;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    we_n        = 1'b0;
    err_n       = err_q;
    case (st)
      IDLE: begin
        if (bus.start) begin
          st_n  = LOAD;
          idx_n = '0;
          err_n = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_n    = 1'b1;
          addr_n  = BASE_A + ADDR_WIDTH'(idx);
          wdata_n = bus.coeff_data;
          idx_n   = idx + 1'b1;
          if (idx == LAST) begin
            st_n        = CTRL;
            ctrl_sent_n = 1'b0;
          end
        end
      end
      CTRL: begin
        // First cycle: the last coefficient write is on the bus, so the
        // CTRL write is queued. Second cycle: the CTRL write is on the bus.
        if (!ctrl_sent) begin
          we_n        = 1'b1;
          addr_n      = CTRL_A;
          wdata_n     = CTRL_V;
          ctrl_sent_n = 1'b1;
        end else begin
`ifdef PAK_DSP_CFG_VERIFY_EN
          st_n   = VERIFY;
          idx_n  = '0;
          addr_n = BASE_A;
`else
          st_n   = DONE;
`endif
        end
      end
`ifdef PAK_DSP_CFG_VERIFY_EN
      VERIFY: begin
        // addr already points at COEFF_BASE+idx; rdata is combinational.
        if (bus.rdata != shadow[idx]) err_n = 1'b1;
        if (idx == LAST) begin
          st_n = DONE;
        end else begin
          idx_n  = idx + 1'b1;
          addr_n = BASE_A + ADDR_WIDTH'(idx) + 1'b1;
        end
      end
`endif
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  assign bus.coeff_ready = (st == LOAD);
  assign bus.busy        = (st != IDLE);
  assign bus.done        = (st == DONE);
  assign bus.addr        = addr_q;
  assign bus.wdata       = wdata_q;
  assign bus.write_en    = we_q;
`ifdef PAK_DSP_CFG_VERIFY_EN
  assign bus.error       = err_q;
`else
  assign bus.error       = 1'b0;
  logic unused_err;
  assign unused_err = err_q ^ err_n;
`endif
endmodule

// File: tb/tb_pak_dsp_cfg_loader.sv
// Directed bench for pak_dsp_cfg_loader with a simple register-file
// responder standing in for pak_dsp.
module tb_pak_dsp_cfg_loader;
`ifdef PAK_DSP_CFG_VERIFY_EN
  localparam int VX = 16;
`else
  localparam int VX = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pak_dsp_cfg_loader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) ifc ();
  pak_dsp_cfg_loader dut (.clk(clk), .rst(rst), .bus(ifc));

  // Responder register file
  logic [15:0] mem [64];
  logic        corrupt = 1'b0;
  always @(posedge clk) if (ifc.write_en) mem[ifc.addr] <= ifc.wdata;
  assign ifc.rdata = (corrupt && ifc.addr == 6'd35) ? 16'hDEAD : mem[ifc.addr];

  // Bus monitor
  int   wa[$], wd[$], wc[$], dc[$];
  logic err_d, busy_d, busy_after, last_done = 1'b0;
  always @(negedge clk) begin
    if (ifc.write_en === 1'b1) begin
      wa.push_back(int'(ifc.addr)); wd.push_back(int'(ifc.wdata)); wc.push_back(cyc);
    end
    if (last_done) busy_after = ifc.busy;
    if (ifc.done === 1'b1) begin
      dc.push_back(cyc); err_d = ifc.error; busy_d = ifc.busy;
    end
    last_done = (ifc.done === 1'b1);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk); #1;
    ifc.start = 1'b1; t = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  // Feeds n beats; p=period of coeff_valid (1 = held high); kick_at>0 pulses
  // start right after that many beats were accepted.
  task automatic stream(input int t, input int p, input logic [15:0] d0,
                        input int n, input int kick_at);
    int   cnt = 0;
    int   guard = 0;
    logic acc;
    while (cnt < n && guard < 200) begin
      @(negedge clk); acc = ifc.coeff_valid && ifc.coeff_ready;
      @(posedge clk); #1;
      if (acc) begin cnt++; ifc.coeff_data = d0 + 16'(cnt); end
      ifc.start = (kick_at > 0 && acc && cnt == kick_at);
      ifc.coeff_valid = (cnt < n) && (((cyc - t) % p) == 0);
      guard++;
    end
    ifc.start = 1'b0; ifc.coeff_valid = 1'b0;
    total++;
    if (cnt != n) begin bad++; $display("FAIL stream_timeout beats=%0d want=%0d", cnt, n); end
  endtask

  task automatic wait_done();
    int g = 0;
    while (dc.size() == 0 && g < 100) begin @(posedge clk); #1; g++; end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifc.start = 1'b1; ifc.coeff_valid = 1'b1; ifc.coeff_data = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++; if (ifc.write_en !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", ifc.write_en); end
      total++; if (ifc.coeff_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ifc.coeff_ready); end
      total++; if ({ifc.busy, ifc.done, ifc.error} !== 3'b000) begin
        bad++; $display("FAIL rst_status got=%b want=000", {ifc.busy, ifc.done, ifc.error}); end
      total++; if (ifc.addr !== 6'd0 || ifc.wdata !== 16'd0) begin
        bad++; $display("FAIL rst_bus addr=%0d wdata=%0h want 0/0", ifc.addr, ifc.wdata); end
    end
    rst = 1'b0; ifc.start = 1'b0; ifc.coeff_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (wa.size() != 0) begin bad++; $display("FAIL rst_no_write got=%0d want=0", wa.size()); end
    clear_log();
  endtask

  task automatic test_stream();
    int t;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL stream_busy got=%b want=1", ifc.busy); end
    stream(t, 1, 16'd1, 16, 0);
    wait_done();
    total++; if (wa.size() != 17) begin bad++; $display("FAIL stream_nwr got=%0d want=17", wa.size()); end
    for (int i = 0; i < 17 && i < wa.size(); i++) begin
      total++; if (wa[i] != ((i < 16) ? 31 + i : 0)) begin bad++; $display("FAIL stream_addr[%0d] got=%0d want=%0d", i, wa[i], (i < 16) ? 31 + i : 0); end
      total++; if (wd[i] != ((i < 16) ? i + 1 : 64)) begin bad++; $display("FAIL stream_data[%0d] got=%0d want=%0d", i, wd[i], (i < 16) ? i + 1 : 64); end
      total++; if (wc[i] != t + 2 + i) begin bad++; $display("FAIL stream_cyc[%0d] got=%0d want=%0d", i, wc[i] - t, 2 + i); end
    end
    total++; if (dc.size() != 1) begin bad++; $display("FAIL stream_ndone got=%0d want=1", dc.size()); end
    else begin
      total++; if (dc[0] != t + 19 + VX) begin bad++; $display("FAIL stream_done_cyc got=%0d want=%0d", dc[0] - t, 19 + VX); end
      total++; if (busy_d !== 1'b1 || busy_after !== 1'b0) begin bad++; $display("FAIL stream_busy_fall at=%b after=%b want 1/0", busy_d, busy_after); end
      total++; if (err_d !== 1'b0) begin bad++; $display("FAIL stream_err got=%b want=0", err_d); end
    end
  endtask

  task automatic test_bubbles();
    int t;
    clear_log();
    ifc.coeff_data = 16'h0100; ifc.coeff_valid = 1'b0;
    pulse_start(t);
    stream(t, 2, 16'h0100, 16, 0);
    wait_done();
    total++; if (wa.size() != 17) begin bad++; $display("FAIL bub_nwr got=%0d want=17", wa.size()); end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      total++; if (wa[i] != 31 + i || wd[i] != 32'h100 + i) begin bad++; $display("FAIL bub_wr[%0d] addr=%0d data=%0h want %0d/%0h", i, wa[i], wd[i], 31 + i, 32'h100 + i); end
      total++; if (wc[i] != t + 3 + 2 * i) begin bad++; $display("FAIL bub_cyc[%0d] got=%0d want=%0d", i, wc[i] - t, 3 + 2 * i); end
    end
    if (wa.size() == 17) begin
      total++; if (wa[16] != 0 || wd[16] != 64 || wc[16] != t + 34) begin
        bad++; $display("FAIL bub_ctrl addr=%0d data=%0d cyc=%0d want 0/64/34", wa[16], wd[16], wc[16] - t); end
    end
    total++; if (dc.size() != 1 || dc[0] != t + 35 + VX) begin
      bad++; $display("FAIL bub_done n=%0d cyc=%0d want 1/%0d", dc.size(), (dc.size() > 0) ? dc[0] - t : -1, 35 + VX); end
  endtask

  task automatic test_ignored_start();
    int t;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    stream(t, 1, 16'd1, 16, 4);
    while (cyc < t + 19 + VX) begin @(posedge clk); #1; end
    total++; if (ifc.done !== 1'b1) begin bad++; $display("FAIL ign_done_cycle got=%b want=1", ifc.done); end
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total++; if (wa.size() != 17) begin bad++; $display("FAIL ign_nwr got=%0d want=17", wa.size()); end
    for (int i = 0; i < 17 && i < wa.size(); i++) begin
      total++; if (wa[i] != ((i < 16) ? 31 + i : 0)) begin bad++; $display("FAIL ign_addr[%0d] got=%0d want=%0d", i, wa[i], (i < 16) ? 31 + i : 0); end
    end
    total++; if (dc.size() != 1) begin bad++; $display("FAIL ign_ndone got=%0d want=1", dc.size()); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL ign_idle busy=%b want=0", ifc.busy); end
  endtask

  task automatic test_reset_mid_load();
    int t;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    stream(t, 1, 16'd1, 5, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (ifc.busy !== 1'b0 || ifc.coeff_ready !== 1'b0 || ifc.write_en !== 1'b0) begin
      bad++; $display("FAIL mid_rst busy=%b ready=%b we=%b want 0/0/0", ifc.busy, ifc.coeff_ready, ifc.write_en); end
    total++; if (wa.size() != 5 || wa[4] != 35) begin
      bad++; $display("FAIL mid_partial n=%0d want=5 (last 35)", wa.size()); end
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    stream(t, 1, 16'd1, 16, 0);
    wait_done();
    total++; if (wa.size() != 17) begin bad++; $display("FAIL mid_nwr got=%0d want=17", wa.size()); end
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      total++; if (wa[i] != 31 + i || wd[i] != i + 1) begin bad++; $display("FAIL mid_wr[%0d] addr=%0d data=%0d want %0d/%0d", i, wa[i], wd[i], 31 + i, i + 1); end
    end
    total++; if (dc.size() != 1 || dc[0] != t + 19 + VX) begin
      bad++; $display("FAIL mid_done n=%0d cyc=%0d want 1/%0d", dc.size(), (dc.size() > 0) ? dc[0] - t : -1, 19 + VX); end
  endtask

`ifdef PAK_DSP_CFG_VERIFY_EN
  task automatic test_verify();
    int t;
    corrupt = 1'b0;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    stream(t, 1, 16'd1, 16, 0);
    wait_done();
    total++; if (dc.size() != 1 || err_d !== 1'b0) begin bad++; $display("FAIL ver_clean n=%0d err=%b want 1/0", dc.size(), err_d); end
    corrupt = 1'b1;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    stream(t, 1, 16'd1, 16, 0);
    wait_done();
    total++; if (dc.size() != 1 || err_d !== 1'b1) begin bad++; $display("FAIL ver_bad n=%0d err=%b want 1/1", dc.size(), err_d); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (ifc.error !== 1'b1) begin bad++; $display("FAIL ver_sticky got=%b want=1", ifc.error); end
    corrupt = 1'b0;
    clear_log();
    ifc.coeff_data = 16'd1; ifc.coeff_valid = 1'b1;
    pulse_start(t);
    total++; if (ifc.error !== 1'b0) begin bad++; $display("FAIL ver_clear got=%b want=0", ifc.error); end
    stream(t, 1, 16'd1, 16, 0);
    wait_done();
    total++; if (err_d !== 1'b0) begin bad++; $display("FAIL ver_reclean got=%b want=0", err_d); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    ifc.start = 1'b0; ifc.coeff_valid = 1'b0; ifc.coeff_data = 16'h0;
    test_reset();
    test_stream();
    test_bubbles();
    test_ignored_start();
    test_reset_mid_load();
`ifdef PAK_DSP_CFG_VERIFY_EN
    test_verify();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
